encoder_pwm_array: RTL and testbench

- Parametrised successor to the three-channel RGB mixer core: NUM_CH quadrature rotary encoders, each driving a WIDTH-bit level register and one PWM output.
- Adds per-input debounce filtering, a runtime step size, wrap or saturate mode, per-channel preset load and a glitch-free PWM duty update.
- Sits directly behind the top-level pin wrapper: encoder pins in, PWM pins and level values out.

---
 rtl/encoder_pwm_array_pkg.sv | 41 ++++
 rtl/encoder_pwm_array_channel.sv | 90 +++++++++
 rtl/encoder_pwm_array.sv | 79 +++++++
 tb/tb_encoder_pwm_array.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_pwm_array_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | rgb_mixer_pkg : shared constants and level arithmetic for the encoder    |
// | PWM array.                                            Revision: 1.0      |
// +--------------------------------------------------------------------------+
package rgb_mixer_pkg;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Widest supported level; sat_add works at this width and masks to the
  // channel width passed in.
  localparam int MAX_W = 12;
  localparam int SUM_W = MAX_W + 1;

  function automatic int cnt_width(input int debounce);
    return $clog2(debounce + 1);
  endfunction

  function automatic logic [MAX_W-1:0] sat_add(
    input logic [MAX_W-1:0] level,
    input logic [MAX_W-1:0] step,
    input logic             up,
    input logic             sat,
    input int               width
  );
    logic [SUM_W-1:0] max_v;
    logic [SUM_W-1:0] sum;
    max_v = (SUM_W'(1) << width) - SUM_W'(1);
    if (up) begin
      sum = {1'b0, level} + {1'b0, step};
      if (sum > max_v) sum = (sat == MODE_SAT) ? max_v : (sum & max_v);
    end else begin
      sum = {1'b0, level} - {1'b0, step};
      if (sum[MAX_W]) sum = (sat == MODE_SAT) ? '0 : (sum & max_v);
    end
    return sum[MAX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/encoder_pwm_array_channel.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_channel : sync + debounce of one quadrature encoder, decode and  |
// | level register with preset load.                      Revision: 1.0      |
// +--------------------------------------------------------------------------+
module encoder_channel
  import rgb_mixer_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int STEP_W   = 4
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              enc_a_i,
  input  logic              enc_b_i,
  input  logic              sat_mode_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              load_i,
  input  logic [WIDTH-1:0]  load_val_i,
  output logic [WIDTH-1:0]  level_o
);

  localparam int              CNT_W    = cnt_width(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE - 1);

  logic [1:0]       raw_w, meta_q, sync_q, filt_w;
  logic             filt_a_q;
  logic             event_w, up_w;
  logic [WIDTH-1:0] level_q, level_d;

  assign raw_w = {enc_b_i, enc_a_i};

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_w;
      sync_q <= meta_q;
    end
  end

  // Index 0 filters phase A, index 1 filters phase B.
  for (genvar i = 0; i < 2; i++) begin : g_deb
    logic [CNT_W-1:0] cnt_q;
    logic             filt_q;
    always_ff @(posedge clk_i) begin
      if (reset_i) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync_q[i] == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        filt_q <= sync_q[i];
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
    assign filt_w[i] = filt_q;
  end

  assign event_w = filt_w[0] != filt_a_q;
  assign up_w    = filt_w[0] != filt_w[1];

  always_comb begin
    level_d = level_q;
    if (load_i) begin
      level_d = load_val_i;
    end else if (event_w) begin
      level_d = WIDTH'(sat_add(MAX_W'(level_q), MAX_W'(WIDTH'(step_i)),
                               up_w, sat_mode_i, WIDTH));
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      filt_a_q <= 1'b0;
      level_q  <= '0;
    end else begin
      filt_a_q <= filt_w[0];
      level_q  <= level_d;
    end
  end

  assign level_o = level_q;

endmodule
`default_nettype wire

// File: rtl/encoder_pwm_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | encoder_pwm_array : NUM_CH encoder-driven level registers, each feeding  |
// | a glitch-free PWM output.                             Revision: 1.0      |
// +--------------------------------------------------------------------------+
module encoder_pwm_array
  import rgb_mixer_pkg::*;
#(
  parameter int NUM_CH   = 3,
  parameter int WIDTH    = 8,
  parameter int DEBOUNCE = 4,
  parameter int STEP_W   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       enc_a,
  input  logic [NUM_CH-1:0]       enc_b,
  input  logic                    en,
  input  logic                    sat_mode,
  input  logic [STEP_W-1:0]       step,
  input  logic [NUM_CH-1:0]       load,
  input  logic [WIDTH-1:0]        load_val,
  output logic [NUM_CH*WIDTH-1:0] level,
  output logic [NUM_CH-1:0]       pwm_out
);

  // Period is 2^WIDTH-1 so that a full-scale duty stays high continuously.
  localparam logic [WIDTH-1:0] CNT_WRAP = WIDTH'((1 << WIDTH) - 2);

  logic [WIDTH-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [NUM_CH-1:0] pwm_d, pwm_q;

  assign pwm_cnt_d = (pwm_cnt_q == CNT_WRAP) ? '0 : pwm_cnt_q + 1'b1;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] duty_q;

    encoder_channel #(
      .WIDTH    (WIDTH),
      .DEBOUNCE (DEBOUNCE),
      .STEP_W   (STEP_W)
    ) u_chan (
      .clk_i      (clk),
      .reset_i    (reset),
      .enc_a_i    (enc_a[i]),
      .enc_b_i    (enc_b[i]),
      .sat_mode_i (sat_mode),
      .step_i     (step),
      .load_i     (load[i]),
      .load_val_i (load_val),
      .level_o    (level[i*WIDTH +: WIDTH])
    );

    // Duty only moves at the period boundary, so no period is cut short.
    always_ff @(posedge clk) begin
      if (reset) begin
        duty_q <= '0;
      end else if (pwm_cnt_q == CNT_WRAP) begin
        duty_q <= level[i*WIDTH +: WIDTH];
      end
    end

    assign pwm_d[i] = (pwm_cnt_q < duty_q) & en;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      pwm_q     <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      pwm_q     <= pwm_d;
    end
  end

  assign pwm_out = pwm_q;

endmodule
`default_nettype wire

// File: tb/tb_encoder_pwm_array.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_encoder_pwm_array : directed vectors for the encoder PWM array.       |
// |                                                       Revision: 1.0      |
// +--------------------------------------------------------------------------+
module tb_encoder_pwm_array;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  enc_a, enc_b, load, pwm_out;
  logic        en, sat_mode;
  logic [3:0]  step;
  logic [7:0]  load_val;
  logic [23:0] level;

  int tests = 0;
  int fails = 0;
  int mc;  // reference PWM counter value

  always #5 clk = ~clk;

  encoder_pwm_array #(
    .NUM_CH(3), .WIDTH(8), .DEBOUNCE(4), .STEP_W(4)
  ) dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b), .en(en),
    .sat_mode(sat_mode), .step(step), .load(load), .load_val(load_val),
    .level(level), .pwm_out(pwm_out)
  );

  always @(posedge clk) begin
    if (reset) mc <= 0;
    else       mc <= (mc == 254) ? 0 : mc + 1;
  end

  typedef struct {
    bit         do_load;
    logic [7:0] lval;
    bit         up;
    bit         sat;
    logic [3:0] stp;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lvl(input int ch);
    return int'(level[ch*8 +: 8]);
  endfunction

  task automatic toggle_a(input int ch);
    enc_a[ch] = ~enc_a[ch];
    repeat (10) tick();
  endtask

  task automatic toggle_b(input int ch);
    enc_b[ch] = ~enc_b[ch];
    repeat (10) tick();
  endtask

  // Up needs A != B after the A edge; pre-align B (no event) when required.
  task automatic detent(input int ch, input bit up);
    if (up ? (enc_a[ch] != enc_b[ch]) : (enc_a[ch] == enc_b[ch])) toggle_b(ch);
    toggle_a(ch);
  endtask

  task automatic do_load(input logic [2:0] mask, input logic [7:0] val);
    load = mask;
    load_val = val;
    tick();
    load = '0;
  endtask

  // Counts pwm_out highs over one full period aligned to the duty latch.
  task automatic measure(input bit cont, input bit mid, input logic [7:0] midval,
                         output int c0, output int c1, output int c2);
    int n;
    c0 = 0; c1 = 0; c2 = 0;
    if (!cont) begin
      n = 0;
      do begin
        tick();
        n++;
      end while (mc != 0 && n < 300);
      check("pwm_period_sync", int'(mc == 0), 1);
    end
    for (int i = 0; i < 255; i++) begin
      tick();
      c0 += int'(pwm_out[0]);
      c1 += int'(pwm_out[1]);
      c2 += int'(pwm_out[2]);
      if (mid && i == 100) begin
        load = 3'b111;
        load_val = midval;
      end
      if (mid && i == 101) load = '0;
    end
  endtask

  initial begin
    int c0, c1, c2;

    vecs[0] = '{1'b1, 8'd250, 1'b1, 1'b1, 4'd8,  8'd255};
    vecs[1] = '{1'b0, 8'd0,   1'b0, 1'b1, 4'd8,  8'd247};
    vecs[2] = '{1'b1, 8'd250, 1'b1, 1'b0, 4'd8,  8'd2};
    vecs[3] = '{1'b1, 8'd3,   1'b0, 1'b0, 4'd8,  8'd251};
    vecs[4] = '{1'b1, 8'd5,   1'b0, 1'b1, 4'd8,  8'd0};
    vecs[5] = '{1'b0, 8'd0,   1'b1, 1'b0, 4'd0,  8'd0};
    vecs[6] = '{1'b0, 8'd0,   1'b1, 1'b0, 4'd15, 8'd15};
    vecs[7] = '{1'b0, 8'd0,   1'b0, 1'b1, 4'd1,  8'd14};
    vecs[8] = '{1'b1, 8'd255, 1'b1, 1'b1, 4'd1,  8'd255};
    vecs[9] = '{1'b1, 8'd0,   1'b0, 1'b0, 4'd1,  8'd255};

    reset = 1'b1; en = 1'b1; sat_mode = 1'b0; step = 4'd1;
    load = '0; load_val = '0;
    enc_a = 3'($urandom); enc_b = 3'($urandom);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("reset_level", int'(level), 0);
      check("reset_pwm", int'(pwm_out), 0);
      enc_a = 3'($urandom); enc_b = 3'($urandom);
    end
    enc_a = '0; enc_b = '0; reset = 1'b0;
    repeat (10) tick();
    check("idle_level", int'(level), 0);

    // Exact latency: A rises just after edge k, level moves at edge k+7.
    enc_a[0] = 1'b1;
    repeat (6) tick();
    check("detent_k6", lvl(0), 0);
    tick();
    check("detent_k7", lvl(0), 1);
    check("detent_ch1", lvl(1), 0);
    check("detent_ch2", lvl(2), 0);
    repeat (3) tick();

    toggle_b(1);
    check("b_only_no_event", lvl(1), 0);
    toggle_b(1);

    enc_a[0] = 1'b0;
    repeat (3) tick();
    enc_a[0] = 1'b1;
    repeat (10) tick();
    check("glitch3_reject", lvl(0), 1);

    enc_a[0] = 1'b0;
    repeat (4) tick();
    enc_a[0] = 1'b1;
    repeat (3) tick();
    check("glitch4_fall_down", lvl(0), 0);
    repeat (6) tick();
    check("glitch4_rise_up", lvl(0), 1);

    detent(0, 1'b1);
    detent(0, 1'b1);
    check("quad_up_x2", lvl(0), 3);

    for (int v = 0; v < 10; v++) begin
      if (vecs[v].do_load) do_load(3'b001, vecs[v].lval);
      sat_mode = vecs[v].sat;
      step = vecs[v].stp;
      detent(0, vecs[v].up);
      check($sformatf("vec%0d", v), lvl(0), int'(vecs[v].exp));
    end

    // Load lands on the same edge as a ch2 up event and must win.
    sat_mode = 1'b0; step = 4'd1;
    enc_a[2] = 1'b1;
    repeat (6) tick();
    load = 3'b100; load_val = 8'h80;
    tick();
    load = '0;
    check("load_precedence", lvl(2), 8'h80);
    repeat (5) tick();
    detent(2, 1'b1);
    check("load_then_event", lvl(2), 8'h81);

    do_load(3'b111, 8'd64);
    measure(1'b0, 1'b1, 8'd200, c0, c1, c2);
    check("pwm64_ch0", c0, 64);
    check("pwm64_ch1", c1, 64);
    check("pwm64_ch2", c2, 64);
    measure(1'b1, 1'b0, 8'd0, c0, c1, c2);
    check("pwm200_ch0", c0, 200);
    check("pwm200_ch1", c1, 200);
    check("pwm200_ch2", c2, 200);

    do_load(3'b001, 8'd0);
    do_load(3'b010, 8'd255);
    do_load(3'b100, 8'd64);
    measure(1'b0, 1'b0, 8'd0, c0, c1, c2);
    check("pwm_duty0", c0, 0);
    check("pwm_duty255", c1, 255);
    check("pwm_duty64", c2, 64);

    en = 1'b0;
    measure(1'b0, 1'b0, 8'd0, c0, c1, c2);
    check("pwm_en0_ch0", c0, 0);
    check("pwm_en0_ch1", c1, 0);
    check("pwm_en0_ch2", c2, 0);
    en = 1'b1;

    repeat (3) tick();
    reset = 1'b1;
    load = 3'b111; load_val = 8'h55;
    tick();
    check("midreset_level", int'(level), 0);
    check("midreset_pwm", int'(pwm_out), 0);
    reset = 1'b0; load = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
